piso_tx_arbiter: RTL and testbench

- Two-requester serial transmit controller built around an internal parallel-in/serial-out shifter.
- Arbitrates round-robin between two parallel-word sources using a valid/ready handshake.
- Loads the granted word and shifts it out MSB-first, with frame-start/frame-end strobes.
- Inserts a programmable idle gap between frames. Sits between upstream word producers and a single-bit serial link.

---
 rtl/piso_tx_arbiter.sv | 174 +++++++++++++++++
 tb/tb_piso_tx_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/piso_tx_arbiter.sv
// rtl/piso_tx_arbiter.sv - two-requester round-robin arbiter feeding an MSB-first serial shifter
// Frames are WIDTH bits long and followed by GAP_CYCLES idle cycles; flush aborts the frame on the line.
module piso_tx_arbiter #(
  parameter int WIDTH      = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  input  logic [WIDTH-1:0] req_data0,
  input  logic [WIDTH-1:0] req_data1,
  output logic [1:0]       req_ready,
  input  logic             flush,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             frame_end,
  output logic             grant_id,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_TOP = CW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_TOP = GW'(GAP_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_reg_q, shift_reg_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
  logic             ser_out_q, ser_out_d;
  logic             ser_valid_q, ser_valid_d;
  logic             frame_start_q, frame_start_d;
  logic             frame_end_q, frame_end_d;
  logic             grant_q, grant_d;
  logic             last_grant_q, last_grant_d;

  logic             any_valid;
  logic             grant_sel;
  logic [WIDTH-1:0] grant_word;

  // Round-robin pick: on contention the requester that did not win last time goes next.
  always_comb begin
    any_valid = |req_valid;
    grant_sel = 1'b0;
    case (req_valid)
      2'b01:   grant_sel = 1'b0;
      2'b10:   grant_sel = 1'b1;
      2'b11:   grant_sel = ~last_grant_q;
      default: grant_sel = 1'b0;
    endcase
    grant_word = grant_sel ? req_data1 : req_data0;
  end

  always_comb begin
    req_ready = 2'b00;
    if (state_q == S_IDLE && any_valid) begin
      req_ready = grant_sel ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      shift_reg_q   <= '0;
      bit_cnt_q     <= '0;
      gap_cnt_q     <= '0;
      ser_out_q     <= 1'b0;
      ser_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      grant_q       <= 1'b0;
      last_grant_q  <= 1'b1;
    end else begin
      state_q       <= state_d;
      shift_reg_q   <= shift_reg_d;
      bit_cnt_q     <= bit_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      ser_out_q     <= ser_out_d;
      ser_valid_q   <= ser_valid_d;
      frame_start_q <= frame_start_d;
      frame_end_q   <= frame_end_d;
      grant_q       <= grant_d;
      last_grant_q  <= last_grant_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    shift_reg_d   = shift_reg_q;
    bit_cnt_d     = bit_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    ser_out_d     = ser_out_q;
    ser_valid_d   = ser_valid_q;
    frame_start_d = frame_start_q;
    frame_end_d   = frame_end_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;

    case (state_q)
      S_IDLE: begin
        if (any_valid) begin
          shift_reg_d   = grant_word;
          ser_out_d     = grant_word[WIDTH-1];
          ser_valid_d   = 1'b1;
          frame_start_d = 1'b1;
          frame_end_d   = 1'b0;
          grant_d       = grant_sel;
          last_grant_d  = grant_sel;
          bit_cnt_d     = CNT_TOP;
          state_d       = S_SHIFT;
        end
      end

      S_SHIFT: begin
        frame_start_d = 1'b0;
        if (flush) begin
          ser_valid_d = 1'b0;
          ser_out_d   = 1'b0;
          frame_end_d = 1'b0;
          state_d     = S_IDLE;
        end else if (bit_cnt_q == '0) begin
          // bit 0 has been on the line for its cycle; close the frame
          ser_valid_d = 1'b0;
          ser_out_d   = 1'b0;
          frame_end_d = 1'b0;
          gap_cnt_d   = GAP_TOP;
          state_d     = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
        end else begin
          // the MSB of shift_reg is the bit currently presented
          shift_reg_d = shift_reg_q << 1;
          ser_out_d   = shift_reg_q[WIDTH-2];
          bit_cnt_d   = bit_cnt_q - CW'(1);
          frame_end_d = (bit_cnt_q == CW'(1));
        end
      end

      S_GAP: begin
        if (gap_cnt_q <= GW'(1)) begin
          gap_cnt_d = '0;
          state_d   = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - GW'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign ser_out     = ser_out_q;
  assign ser_valid   = ser_valid_q;
  assign frame_start = frame_start_q;
  assign frame_end   = frame_end_q;
  assign grant_id    = grant_q;
  assign busy        = (state_q != S_IDLE);

  a_ready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));

  a_start_msb: assert property (@(posedge clk) disable iff (rst)
    frame_start |-> (ser_out == shift_reg_q[WIDTH-1]));

  a_frame_len: assert property (@(posedge clk) disable iff (rst)
    frame_end |-> ($past(frame_start, WIDTH - 1) && ser_valid));

endmodule

// File: tb/tb_piso_tx_arbiter.sv
// tb/tb_piso_tx_arbiter.sv - directed self-checking bench for piso_tx_arbiter
module tb_piso_tx_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req_valid;
  logic [3:0] req_data0, req_data1;
  logic [1:0] req_ready;
  logic       flush;
  logic       ser_out, ser_valid, frame_start, frame_end, grant_id, busy;

  logic [1:0] req_valid_z;
  logic [3:0] req_data0_z, req_data1_z;
  logic [1:0] req_ready_z;
  logic       flush_z;
  logic       ser_out_z, ser_valid_z, frame_start_z, frame_end_z, grant_id_z, busy_z;

  int checks = 0;
  int errors = 0;
  logic [3:0] w;

  piso_tx_arbiter #(.WIDTH(4), .GAP_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data0(req_data0),
    .req_data1(req_data1), .req_ready(req_ready), .flush(flush),
    .ser_out(ser_out), .ser_valid(ser_valid), .frame_start(frame_start),
    .frame_end(frame_end), .grant_id(grant_id), .busy(busy)
  );

  piso_tx_arbiter #(.WIDTH(4), .GAP_CYCLES(0)) dut_z (
    .clk(clk), .rst(rst), .req_valid(req_valid_z), .req_data0(req_data0_z),
    .req_data1(req_data1_z), .req_ready(req_ready_z), .flush(flush_z),
    .ser_out(ser_out_z), .ser_valid(ser_valid_z), .frame_start(frame_start_z),
    .frame_end(frame_end_z), .grant_id(grant_id_z), .busy(busy_z)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req_valid = 2'b00; req_data0 = '0; req_data1 = '0; flush = 1'b0;
    req_valid_z = 2'b00; req_data0_z = '0; req_data1_z = '0; flush_z = 1'b0;
    next(); next(); #1;
    chk("rst_ser_out", {3'b0, ser_out}, 4'd0);
    chk("rst_ser_valid", {3'b0, ser_valid}, 4'd0);
    chk("rst_fs", {3'b0, frame_start}, 4'd0);
    chk("rst_fe", {3'b0, frame_end}, 4'd0);
    chk("rst_grant", {3'b0, grant_id}, 4'd0);
    chk("rst_busy", {3'b0, busy}, 4'd0);
    chk("rst_ready", {2'b0, req_ready}, 4'd0);

    // release reset with both requesting: requester 0 wins; it sends 1011
    next();
    rst = 1'b0; req_valid = 2'b11; req_data0 = 4'b1011; req_data1 = 4'b0101;
    #1;
    chk("prio_ready", {2'b0, req_ready}, 4'b0001);
    w = 4'b1011;
    for (int b = 0; b < 4; b++) begin
      next();
      if (b == 0) req_valid = 2'b00;
      #1;
      chk("f1_bit", {3'b0, ser_out}, {3'b0, w[3-b]});
      chk("f1_valid", {3'b0, ser_valid}, 4'd1);
      chk("f1_fs", {3'b0, frame_start}, (b == 0) ? 4'd1 : 4'd0);
      chk("f1_fe", {3'b0, frame_end}, (b == 3) ? 4'd1 : 4'd0);
      chk("f1_grant", {3'b0, grant_id}, 4'd0);
    end
    next(); #1;
    chk("gap1_valid", {3'b0, ser_valid}, 4'd0);
    chk("gap1_fe", {3'b0, frame_end}, 4'd0);
    chk("gap1_busy", {3'b0, busy}, 4'd1);
    next();
    req_valid = 2'b01; req_data0 = 4'b1100;
    #1;
    chk("gap2_ready", {2'b0, req_ready}, 4'd0);
    chk("gap2_valid", {3'b0, ser_valid}, 4'd0);
    next(); #1;
    chk("t7_ready", {2'b0, req_ready}, 4'b0001);
    chk("t7_busy", {3'b0, busy}, 4'd0);

    // flush while bit 2 of 1100 is on the line
    next(); #1;
    chk("fl_msb", {3'b0, ser_out}, 4'd1);
    chk("fl_fs", {3'b0, frame_start}, 4'd1);
    next();
    flush = 1'b1; req_valid = 2'b00;
    #1;
    chk("fl_bit2", {3'b0, ser_out}, 4'd1);
    chk("fl_fe_before", {3'b0, frame_end}, 4'd0);
    next();
    req_valid = 2'b10; req_data1 = 4'b0110;
    #1;
    chk("fl_valid", {3'b0, ser_valid}, 4'd0);
    chk("fl_fe_after", {3'b0, frame_end}, 4'd0);
    chk("fl_busy", {3'b0, busy}, 4'd0);
    chk("fl_ready", {2'b0, req_ready}, 4'b0010);

    // requester 1 sends 0110 while its data input changes mid-frame
    w = 4'b0110;
    for (int b = 0; b < 4; b++) begin
      next();
      if (b == 0) begin
        flush = 1'b0; req_valid = 2'b00;
      end
      if (b == 1) req_data1 = 4'b1001;
      #1;
      chk("dc_bit", {3'b0, ser_out}, {3'b0, w[3-b]});
      chk("dc_grant", {3'b0, grant_id}, 4'd1);
      chk("dc_fe", {3'b0, frame_end}, (b == 3) ? 4'd1 : 4'd0);
    end

    // asynchronous reset in the middle of a frame
    next(); next(); next();
    req_valid = 2'b01; req_data0 = 4'b1111;
    #1;
    chk("pre_rst_ready", {2'b0, req_ready}, 4'b0001);
    next();
    req_valid = 2'b00;
    next(); #1;
    chk("pre_rst_valid", {3'b0, ser_valid}, 4'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", {3'b0, ser_valid}, 4'd0);
    chk("arst_out", {3'b0, ser_out}, 4'd0);
    chk("arst_fs", {3'b0, frame_start}, 4'd0);
    chk("arst_fe", {3'b0, frame_end}, 4'd0);
    chk("arst_busy", {3'b0, busy}, 4'd0);

    // fairness with both requesters held
    next();
    rst = 1'b0; req_valid = 2'b11; req_data0 = 4'b1010; req_data1 = 4'b0101;
    for (int f = 0; f < 4; f++) begin
      #1;
      chk("rr_ready", {2'b0, req_ready}, (f % 2 == 1) ? 4'b0010 : 4'b0001);
      chk("rr_idle_valid", {3'b0, ser_valid}, 4'd0);
      w = (f % 2 == 1) ? 4'b0101 : 4'b1010;
      for (int b = 0; b < 4; b++) begin
        next(); #1;
        chk("rr_bit", {3'b0, ser_out}, {3'b0, w[3-b]});
        chk("rr_valid", {3'b0, ser_valid}, 4'd1);
        chk("rr_grant", {3'b0, grant_id}, (f % 2 == 1) ? 4'd1 : 4'd0);
        chk("rr_fs", {3'b0, frame_start}, (b == 0) ? 4'd1 : 4'd0);
      end
      for (int g = 0; g < 2; g++) begin
        next(); #1;
        chk("rr_gap_valid", {3'b0, ser_valid}, 4'd0);
        chk("rr_gap_ready", {2'b0, req_ready}, 4'd0);
      end
      next();
    end
    req_valid = 2'b00;

    // zero-gap instance: requester 1 held, accepts every 5 cycles
    req_valid_z = 2'b10; req_data1_z = 4'b1001;
    w = 4'b1001;
    for (int c = 0; c < 15; c++) begin
      #1;
      if (c % 5 == 0) begin
        chk("z_ready", {2'b0, req_ready_z}, 4'b0010);
        chk("z_idle_valid", {3'b0, ser_valid_z}, 4'd0);
      end else begin
        chk("z_ready_busy", {2'b0, req_ready_z}, 4'd0);
        chk("z_bit", {3'b0, ser_out_z}, {3'b0, w[4-(c%5)]});
        chk("z_valid", {3'b0, ser_valid_z}, 4'd1);
      end
      next();
    end
    req_valid_z = 2'b00;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
